// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster engine with frame-buffer latency matching
// Stage-0 counters drive the read address; sync/DE ride a delay line so they meet the returned pixel.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int COLOR_W  = 4,
   parameter int ADDR_W   = 19,
   parameter int RD_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_en,
   input  logic                 enable,
   input  logic [3*COLOR_W-1:0] pixel_in,
   output logic                 pixel_rd,
   output logic [ADDR_W-1:0]    pixel_addr,
   output logic [11:0]          x,
   output logic [11:0]          y,
   output logic                 line_start,
   output logic                 frame_start,
   output logic                 h_sync,
   output logic                 v_sync,
   output logic                 de,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int NPIX  = H_ACTIVE * V_ACTIVE;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("vga_timing_gen: RD_LAT must be 1..4");
   end

   logic [11:0]              h_q, h_d, v_q, v_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   // Each delay stage holds {hs, vs, active}, active-high regardless of polarity.
   logic [RD_LAT-1:0][2:0]   dl_q, dl_d;
   logic                     hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic [3*COLOR_W-1:0]     rgb_q, rgb_d;
   logic                     active0, hs0, vs0, run;

   assign active0 = (h_q < 12'(H_ACTIVE)) && (v_q < 12'(V_ACTIVE));
   assign hs0     = (h_q >= 12'(H_ACTIVE + H_FP)) && (h_q < 12'(H_ACTIVE + H_FP + H_SYNC));
   assign vs0     = (v_q >= 12'(V_ACTIVE + V_FP)) && (v_q < 12'(V_ACTIVE + V_FP + V_SYNC));
   assign run     = pix_en & enable & rst_n;

   always_comb begin
      h_d    = h_q;
      v_d    = v_q;
      addr_d = addr_q;
      dl_d   = dl_q;
      hs_d   = hs_q;
      vs_d   = vs_q;
      de_d   = de_q;
      rgb_d  = rgb_q;
      if (!enable) begin
         h_d    = '0;
         v_d    = '0;
         addr_d = '0;
         dl_d   = '0;
         hs_d   = ~H_POL;
         vs_d   = ~V_POL;
         de_d   = 1'b0;
         rgb_d  = '0;
      end else if (pix_en) begin
         if (h_q == 12'(H_TOT - 1)) begin
            h_d = '0;
            v_d = (v_q == 12'(V_TOT - 1)) ? 12'd0 : v_q + 12'd1;
         end else begin
            h_d = h_q + 12'd1;
         end
         // Address wraps by compare rather than being rebuilt from y*H_ACTIVE+x.
         if (active0) begin
            addr_d = (addr_q == ADDR_W'(NPIX - 1)) ? '0 : addr_q + ADDR_W'(1);
         end
         dl_d[0] = {hs0, vs0, active0};
         for (int i = 1; i < RD_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
         end
         hs_d  = dl_q[RD_LAT-1][2] ? H_POL : ~H_POL;
         vs_d  = dl_q[RD_LAT-1][1] ? V_POL : ~V_POL;
         de_d  = dl_q[RD_LAT-1][0];
         rgb_d = dl_q[RD_LAT-1][0] ? pixel_in : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q    <= '0;
         v_q    <= '0;
         addr_q <= '0;
         dl_q   <= '0;
         hs_q   <= ~H_POL;
         vs_q   <= ~V_POL;
         de_q   <= 1'b0;
         rgb_q  <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         addr_q <= addr_d;
         dl_q   <= dl_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         de_q   <= de_d;
         rgb_q  <= rgb_d;
      end
   end

   assign x           = h_q;
   assign y           = v_q;
   assign pixel_addr  = addr_q;
   assign pixel_rd    = active0 & run;
   assign line_start  = run & (h_q == 12'd0);
   assign frame_start = run & (h_q == 12'd0) & (v_q == 12'd0);
   assign h_sync      = hs_q;
   assign v_sync      = vs_q;
   assign de          = de_q;
   assign red         = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign green       = rgb_q[2*COLOR_W-1:COLOR_W];
   assign blue        = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen, three parameter sets
// Reference: tick index n since restart mapped to raster position with plain arithmetic.
module tb_vga_timing_gen;

   typedef struct packed {
      int ha, hf, hs, hb, va, vf, vs, vb, lat;
      bit hp, vp;
   } cfg_t;

   typedef struct packed {
      logic [11:0] x, y;
      logic [18:0] addr;
      logic        rd, ls, fs, hs, vs, de;
      logic [11:0] rgb;
   } out_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b1;
   logic pix_en = 1'b0;
   logic enable = 1'b0;
   logic [2:0][11:0] x_o, y_o, pin;
   logic [2:0]       rd_o, ls_o, fs_o, hs_o, vs_o, de_o;
   logic [2:0][3:0]  r_o, g_o, b_o;
   logic [18:0]      a0;
   logic [6:0]       a1;
   logic [3:0]       a2;
   logic [11:0]      pipe [3][4];

   out_t   obs [3];
   longint n = 0;
   int     n_chk = 0;
   int     n_fail = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .enable(enable), .pixel_in(pin[0]),
      .pixel_rd(rd_o[0]), .pixel_addr(a0), .x(x_o[0]), .y(y_o[0]),
      .line_start(ls_o[0]), .frame_start(fs_o[0]), .h_sync(hs_o[0]), .v_sync(vs_o[0]),
      .de(de_o[0]), .red(r_o[0]), .green(g_o[0]), .blue(b_o[0]));

   vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(2),
                    .V_SYNC(2), .V_BP(2), .ADDR_W(7), .RD_LAT(3)) u_mem (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .enable(enable), .pixel_in(pin[1]),
      .pixel_rd(rd_o[1]), .pixel_addr(a1), .x(x_o[1]), .y(y_o[1]),
      .line_start(ls_o[1]), .frame_start(fs_o[1]), .h_sync(hs_o[1]), .v_sync(vs_o[1]),
      .de(de_o[1]), .red(r_o[1]), .green(g_o[1]), .blue(b_o[1]));

   vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                    .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .ADDR_W(4),
                    .RD_LAT(4)) u_tiny (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .enable(enable), .pixel_in(pin[2]),
      .pixel_rd(rd_o[2]), .pixel_addr(a2), .x(x_o[2]), .y(y_o[2]),
      .line_start(ls_o[2]), .frame_start(fs_o[2]), .h_sync(hs_o[2]), .v_sync(vs_o[2]),
      .de(de_o[2]), .red(r_o[2]), .green(g_o[2]), .blue(b_o[2]));

   // Frame-buffer model: data = address[11:0], returned RD_LAT ticks after the read.
   always @(posedge clk) begin
      if (pix_en && enable && rst_n) begin
         for (int j = 3; j > 0; j--) begin
            for (int k = 0; k < 3; k++) pipe[k][j] <= pipe[k][j-1];
         end
         pipe[0][0] <= a0[11:0];
         pipe[1][0] <= 12'(a1);
         pipe[2][0] <= 12'(a2);
      end
   end
   assign pin[0] = pipe[0][0];
   assign pin[1] = pipe[1][2];
   assign pin[2] = pipe[2][3];

   function automatic cfg_t cfg(input int k);
      case (k)
         0:       return '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0};
         1:       return '{16, 2, 3, 2, 6, 2, 2, 2, 3, 1'b0, 1'b0};
         default: return '{4, 1, 2, 1, 3, 1, 1, 1, 4, 1'b1, 1'b1};
      endcase
   endfunction

   function automatic longint addr_of(input cfg_t c, input longint p);
      longint ht, px, py, cnt;
      ht  = c.ha + c.hf + c.hs + c.hb;
      px  = p % ht;
      py  = p / ht;
      cnt = (py < c.va) ? py * c.ha + ((px < c.ha) ? px : c.ha) : longint'(c.va) * c.ha;
      return cnt % (longint'(c.ha) * c.va);
   endfunction

   function automatic out_t exp_out(input cfg_t c, input longint n_in, input bit pe,
                                    input bit en, input bit rn);
      out_t   o;
      longint ht, fr, nn, p, m, mx, my;
      bit     tick;
      ht   = c.ha + c.hf + c.hs + c.hb;
      fr   = ht * (c.va + c.vf + c.vs + c.vb);
      nn   = rn ? n_in : 0;
      tick = pe && en && rn;
      p    = nn % fr;
      o.x    = 12'(p % ht);
      o.y    = 12'(p / ht);
      o.addr = 19'(addr_of(c, p));
      o.rd   = tick && (p % ht < c.ha) && (p / ht < c.va);
      o.ls   = tick && (p % ht == 0);
      o.fs   = tick && (p == 0);
      o.hs   = ~c.hp;
      o.vs   = ~c.vp;
      o.de   = 1'b0;
      o.rgb  = '0;
      m = nn - c.lat - 1;
      if (m >= 0) begin
         m  = m % fr;
         mx = m % ht;
         my = m / ht;
         if (mx >= c.ha + c.hf && mx < c.ha + c.hf + c.hs) o.hs = c.hp;
         if (my >= c.va + c.vf && my < c.va + c.vf + c.vs) o.vs = c.vp;
         if (mx < c.ha && my < c.va) begin
            o.de  = 1'b1;
            o.rgb = 12'(addr_of(c, m));
         end
      end
      return o;
   endfunction

   task automatic sample();
      obs[0] = {x_o[0], y_o[0], a0, rd_o[0], ls_o[0], fs_o[0], hs_o[0], vs_o[0], de_o[0],
                r_o[0], g_o[0], b_o[0]};
      obs[1] = {x_o[1], y_o[1], 19'(a1), rd_o[1], ls_o[1], fs_o[1], hs_o[1], vs_o[1], de_o[1],
                r_o[1], g_o[1], b_o[1]};
      obs[2] = {x_o[2], y_o[2], 19'(a2), rd_o[2], ls_o[2], fs_o[2], hs_o[2], vs_o[2], de_o[2],
                r_o[2], g_o[2], b_o[2]};
   endtask

   task automatic cyc(input bit pe, input bit en);
      @(posedge clk);
      if (!rst_n || !enable) n = 0;
      else if (pix_en) n++;
      #1;
      pix_en = pe;
      enable = en;
      @(negedge clk);
      sample();
   endtask

   task automatic restart();
      cyc(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      out_t e;
      #1;
      rst_n = 1'b0; enable = 1'b1; pix_en = 1'b1;
      #1;
      sample();
      for (int k = 0; k < 3; k++) begin
         e = exp_out(cfg(k), 0, 1'b1, 1'b1, 1'b0);
         n_chk++;
         if (obs[k] !== e) begin
            n_fail++;
            $display("FAIL reset_async dut%0d got %h exp %h", k, obs[k], e);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
      rst_n = 1'b1;
      #1;
      sample();
      n_chk++;
      if (obs[0].fs !== 1'b1 || obs[0].addr !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_release fs=%b addr=%0d exp fs=1 addr=0", obs[0].fs, obs[0].addr);
      end
      for (int i = 0; i < 40; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_out(cfg(k), n, pix_en, enable, rst_n);
            n_chk++;
            if (obs[k] !== e) begin
               n_fail++;
               $display("FAIL reset_run dut%0d n=%0d got %h exp %h", k, n, obs[k], e);
            end
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      sample();
      for (int k = 0; k < 3; k++) begin
         e = exp_out(cfg(k), 0, pix_en, enable, 1'b0);
         n_chk++;
         if (obs[k] !== e) begin
            n_fail++;
            $display("FAIL reset_midrun dut%0d got %h exp %h", k, obs[k], e);
         end
      end
      cyc(1'b1, 1'b1);
      rst_n = 1'b1;
   endtask

   task automatic test_default_line();
      out_t   e;
      longint ls2 = -1, hs_fall = -1;
      int     hs_low = 0, de_cnt = 0, ls_seen = 0;
      bit     hs_prev = 1'b1;
      restart();
      for (int i = 0; i < 3400; i++) begin
         cyc(i % 4 == 0, 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_out(cfg(k), n, pix_en, enable, rst_n);
            n_chk++;
            if (obs[k] !== e) begin
               n_fail++;
               $display("FAIL line_model dut%0d n=%0d got %h exp %h", k, n, obs[k], e);
            end
         end
         if (pix_en) begin
            if (obs[0].ls) begin
               ls_seen++;
               if (ls_seen == 2) ls2 = n;
            end
            if (hs_prev && !obs[0].hs && hs_fall < 0) hs_fall = n;
            if (n < 800 && !obs[0].hs) hs_low++;
            if (n < 800 && obs[0].de) de_cnt++;
            hs_prev = obs[0].hs;
         end
      end
      n_chk++;
      if (ls2 != 800) begin
         n_fail++; $display("FAIL line_period got %0d exp 800", ls2);
      end
      n_chk++;
      if (hs_fall != 658) begin
         n_fail++; $display("FAIL hsync_start got %0d exp 658", hs_fall);
      end
      n_chk++;
      if (hs_low != 96) begin
         n_fail++; $display("FAIL hsync_width got %0d exp 96", hs_low);
      end
      n_chk++;
      if (de_cnt != 640) begin
         n_fail++; $display("FAIL de_per_line got %0d exp 640", de_cnt);
      end
   endtask

   task automatic test_random_frames();
      out_t e;
      int   rd_cnt = 0, frames = 0;
      bit   first_de = 1'b1, hit_last = 1'b0;
      restart();
      for (int i = 0; i < 2400; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_out(cfg(k), n, pix_en, enable, rst_n);
            n_chk++;
            if (obs[k] !== e) begin
               n_fail++;
               $display("FAIL rand_model dut%0d n=%0d got %h exp %h", k, n, obs[k], e);
            end
         end
         if (obs[1].fs) begin
            if (n > 0) begin
               frames++;
               n_chk++;
               if (rd_cnt != 96) begin
                  n_fail++; $display("FAIL rd_per_frame got %0d exp 96", rd_cnt);
               end
            end
            n_chk++;
            if (obs[1].addr !== 19'd0) begin
               n_fail++; $display("FAIL addr_frame_start got %0d exp 0", obs[1].addr);
            end
            rd_cnt = 0;
         end
         if (obs[1].rd) rd_cnt++;
         if (obs[1].rd && obs[1].x == 12'd15 && obs[1].y == 12'd5) begin
            hit_last = 1'b1;
            n_chk++;
            if (obs[1].addr !== 19'd95) begin
               n_fail++; $display("FAIL addr_last got %0d exp 95", obs[1].addr);
            end
         end
         if (first_de && obs[1].de) begin
            first_de = 1'b0;
            n_chk++;
            if (obs[1].rgb !== 12'd0) begin
               n_fail++; $display("FAIL first_de_rgb got %h exp 000", obs[1].rgb);
            end
         end
      end
      n_chk++;
      if (!hit_last || frames < 2) begin
         n_fail++; $display("FAIL frame_sweep last_hit=%0b frames=%0d exp 1 and >=2", hit_last, frames);
      end
   endtask

   task automatic test_tiny();
      out_t   e;
      longint ls0 = -1, ls1 = -1, fs0 = -1, fs1 = -1, hs_rise = -1, de_rise = -1, de_fall = -1;
      int     hs_hi = 0, vs_hi = 0;
      bit     hs_prev = 1'b0, de_prev = 1'b0;
      restart();
      for (int i = 0; i < 120; i++) begin
         cyc(1'b1, 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_out(cfg(k), n, pix_en, enable, rst_n);
            n_chk++;
            if (obs[k] !== e) begin
               n_fail++;
               $display("FAIL tiny_model dut%0d n=%0d got %h exp %h", k, n, obs[k], e);
            end
         end
         if (obs[2].ls) begin
            if (ls0 < 0) ls0 = n; else if (ls1 < 0) ls1 = n;
         end
         if (obs[2].fs) begin
            if (fs0 < 0) fs0 = n; else if (fs1 < 0) fs1 = n;
         end
         if (!hs_prev && obs[2].hs && hs_rise < 0) hs_rise = n;
         if (!de_prev && obs[2].de && de_rise < 0) de_rise = n;
         if (de_prev && !obs[2].de && de_fall < 0) de_fall = n;
         if (n >= 48 && n < 96) begin
            if (obs[2].hs) hs_hi++;
            if (obs[2].vs) vs_hi++;
         end
         hs_prev = obs[2].hs;
         de_prev = obs[2].de;
      end
      n_chk++;
      if (ls1 - ls0 != 8) begin
         n_fail++; $display("FAIL tiny_line got %0d exp 8", ls1 - ls0);
      end
      n_chk++;
      if (fs1 - fs0 != 48) begin
         n_fail++; $display("FAIL tiny_frame got %0d exp 48", fs1 - fs0);
      end
      n_chk++;
      if (hs_rise != 10) begin
         n_fail++; $display("FAIL tiny_hsync_pos got %0d exp 10", hs_rise);
      end
      n_chk++;
      if (hs_hi != 12 || vs_hi != 8) begin
         n_fail++; $display("FAIL tiny_sync_count got hs=%0d vs=%0d exp hs=12 vs=8", hs_hi, vs_hi);
      end
      n_chk++;
      if (de_fall - de_rise != 4) begin
         n_fail++; $display("FAIL tiny_de_width got %0d exp 4", de_fall - de_rise);
      end
   endtask

   task automatic test_enable_toggle();
      out_t   e;
      longint fs_n = -1, de_n = -1;
      restart();
      for (int i = 0; i < 41000 && n < 40099; i++) cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b0);
      n_chk++;
      if (obs[0].x !== 12'd100 || obs[0].y !== 12'd50 || obs[0].rd !== 1'b0) begin
         n_fail++;
         $display("FAIL en_drop_pos got x=%0d y=%0d rd=%b exp x=100 y=50 rd=0",
                  obs[0].x, obs[0].y, obs[0].rd);
      end
      cyc(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         e = exp_out(cfg(k), 0, 1'b1, 1'b0, 1'b1);
         n_chk++;
         if (obs[k] !== e) begin
            n_fail++;
            $display("FAIL en_idle dut%0d got %h exp %h", k, obs[k], e);
         end
      end
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b1);
         for (int k = 0; k < 3; k++) begin
            e = exp_out(cfg(k), n, pix_en, enable, rst_n);
            n_chk++;
            if (obs[k] !== e) begin
               n_fail++;
               $display("FAIL en_resume dut%0d n=%0d got %h exp %h", k, n, obs[k], e);
            end
         end
         if (obs[0].fs && fs_n < 0) fs_n = i;
         if (obs[0].de && de_n < 0) de_n = i;
      end
      n_chk++;
      if (fs_n != 0 || de_n <= fs_n) begin
         n_fail++; $display("FAIL en_restart_order got fs_at=%0d de_at=%0d exp fs_at=0 de_at>0", fs_n, de_n);
      end
   endtask

   initial begin
      test_reset();
      test_default_line();
      test_random_frames();
      test_tiny();
      test_enable_toggle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
